// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: registered output/enable per pad, synchronized and
// debounced input path, rising-edge interrupt-pending flags.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   reg_ctrl_i     2 mode bits per pad (00 hi-Z, 01 out, 10 in, 11 hi-Z)
//   reg_data_i     bit i = output value for pad i
//   pad_i          raw pad inputs (asynchronous)
//   pad_o          registered pad output values
//   pad_oe_o       registered pad output enables
//   pin_o          debounced input value, gated by input mode
//   irq_clr_i      per-pad pending clear pulse
//   irq_pend_o     per-pad pending flags
//   irq_o          OR of pending flags
module gpio_pad_ctrl #(
  parameter int unsigned NUM_IO   = 2,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       reg_ctrl_i,
  input  logic [31:0]       reg_data_i,
  input  logic [NUM_IO-1:0] pad_i,
  output logic [NUM_IO-1:0] pad_o,
  output logic [NUM_IO-1:0] pad_oe_o,
  output logic [NUM_IO-1:0] pin_o,
  input  logic [NUM_IO-1:0] irq_clr_i,
  output logic [NUM_IO-1:0] irq_pend_o,
  output logic              irq_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [NUM_IO-1:0] is_out;
  logic [NUM_IO-1:0] is_in;
  logic [NUM_IO-1:0] sync1;
  logic [NUM_IO-1:0] sync2;
  logic [NUM_IO-1:0] stable;
  logic [NUM_IO-1:0] stable_d;
  logic [NUM_IO-1:0] irq_pend;
  logic [CW-1:0]     cnt [NUM_IO];

  // Control bits of pads beyond NUM_IO are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{reg_ctrl_i, reg_data_i};

  always_comb begin
    is_out = '0;
    is_in  = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      is_out[i] = (reg_ctrl_i[2*i +: 2] == 2'b01);
      is_in[i]  = (reg_ctrl_i[2*i +: 2] == 2'b10);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_oe_o <= '0;
      pad_o    <= '0;
      sync1    <= '0;
      sync2    <= '0;
      stable_d <= '0;
      irq_pend <= '0;
    end else begin
      pad_oe_o <= is_out;
      pad_o    <= is_out & reg_data_i[NUM_IO-1:0];
      sync1    <= pad_i;
      sync2    <= sync1;
      stable_d <= stable;
      // Set wins over clear; only a 0->1 of stable seen in input mode sets.
      irq_pend <= (stable & ~stable_d & is_in)
                | (irq_pend & ~irq_clr_i);
    end
  end

  // Debounce: stable follows sync2 only after DEBOUNCE consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign pin_o      = stable & is_in;
  assign irq_pend_o = irq_pend;
  assign irq_o      = |irq_pend;

endmodule
